// File: rtl/frame_src.sv
// Test-frame source: emits vs-framed lines of RGB565 pixels (bars, gradient,
// solid or checker) with configurable active area, line blanking and frame gaps.
module frame_src #(
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480,
  parameter int H_BLANK = 16,
  parameter int V_PRE   = 8,
  parameter int V_POST  = 8,
  parameter int V_GAP   = 32,
  parameter int BAR_W   = 80,
  parameter int P_W     = 12
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        i_en,
  input  logic [1:0]  i_pattern,
  input  logic [15:0] i_color,
  output logic        o_post_camvs,
  output logic        o_valid,
  output logic [15:0] o_data,
  output logic        o_frame_done,
  output logic [7:0]  o_frame_cnt
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // One shared timer covers every non-LINE phase; LINE is timed by the pixel counter.
  localparam int T_MAX = max4(V_PRE, H_BLANK, V_POST, V_GAP);
  localparam int T_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int B_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VPRE,
    S_LINE,
    S_HBLK,
    S_VPOST,
    S_VGAP
  } state_t;

  state_t         state_q, state_d;
  logic [T_W-1:0] tmr_q, tmr_d;
  logic [P_W-1:0] x_q, x_d;
  logic [P_W-1:0] y_q, y_d;
  logic [2:0]     bar_q, bar_d;
  logic [B_W-1:0] bar_cnt_q, bar_cnt_d;
  logic [1:0]     pat_q;
  logic [15:0]    color_q;
  logic           vs_d, valid_d, done_d, latch_cfg;
  logic [15:0]    pix;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    x_d       = x_q;
    y_d       = y_q;
    bar_d     = bar_q;
    bar_cnt_d = bar_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_en) begin
          state_d = S_VPRE;
          tmr_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_VPRE: begin
        if (tmr_q == T_W'(V_PRE - 1)) begin
          state_d   = S_LINE;
          x_d       = '0;
          bar_d     = '0;
          bar_cnt_d = '0;
        end else begin
          tmr_d = tmr_q + T_W'(1);
        end
      end
      S_LINE: begin
        if (x_q == P_W'(H_ACT - 1)) begin
          state_d = S_HBLK;
          tmr_d   = '0;
        end else begin
          x_d = x_q + P_W'(1);
          if (bar_cnt_q == B_W'(BAR_W - 1)) begin
            bar_cnt_d = '0;
            if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
          end else begin
            bar_cnt_d = bar_cnt_q + B_W'(1);
          end
        end
      end
      S_HBLK: begin
        if (tmr_q == T_W'(H_BLANK - 1)) begin
          tmr_d = '0;
          if (y_q == P_W'(V_ACT - 1)) begin
            state_d = S_VPOST;
          end else begin
            state_d   = S_LINE;
            y_d       = y_q + P_W'(1);
            x_d       = '0;
            bar_d     = '0;
            bar_cnt_d = '0;
          end
        end else begin
          tmr_d = tmr_q + T_W'(1);
        end
      end
      S_VPOST: begin
        if (tmr_q == T_W'(V_POST - 1)) begin
          state_d = S_VGAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + T_W'(1);
        end
      end
      S_VGAP: begin
        if (tmr_q == T_W'(V_GAP - 1)) begin
          tmr_d   = '0;
          x_d     = '0;
          y_d     = '0;
          state_d = i_en ? S_VPRE : S_IDLE;
        end else begin
          tmr_d = tmr_q + T_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state register.
  assign vs_d      = (state_d == S_VPRE) || (state_d == S_LINE) ||
                     (state_d == S_HBLK) || (state_d == S_VPOST);
  assign valid_d   = (state_d == S_LINE);
  assign done_d    = (state_d == S_VPOST) && (tmr_d == T_W'(V_POST - 1));
  assign latch_cfg = (state_d == S_VPRE) && (state_q != S_VPRE);

  always_comb begin
    pix = '0;
    case (pat_q)
      2'd0: begin
        case (bar_d)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = {x_d[4:0], y_d[5:0], x_d[4:0] ^ y_d[4:0]};
      2'd2:    pix = color_q;
      default: pix = (x_d[4] ^ y_d[4]) ? 16'hFFFF : 16'h0000;
    endcase
  end

  // NOTE: state and output registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      bar_q        <= '0;
      bar_cnt_q    <= '0;
      pat_q        <= '0;
      color_q      <= '0;
      o_post_camvs <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bar_q        <= bar_d;
      bar_cnt_q    <= bar_cnt_d;
      if (latch_cfg) begin
        pat_q   <= i_pattern;
        color_q <= i_color;
      end
      o_post_camvs <= vs_d;
      o_valid      <= valid_d;
      o_data       <= valid_d ? pix : 16'h0000;
      o_frame_done <= done_d;
      o_frame_cnt  <= o_frame_cnt + 8'(done_d);
    end
  end

endmodule

// File: tb/tb_frame_src.sv
// Bench for frame_src: a small geometry instance (a) and a 32x32 instance (b),
// checked every cycle against a frame-timeline model plus hand-computed values.
module tb_frame_src;

  localparam int H_A = 4,  V_A = 2,  HB_A = 2, PRE_A = 3, POST_A = 3, GAP_A = 5, BW_A = 2;
  localparam int H_B = 32, V_B = 32, HB_B = 2, PRE_B = 3, POST_B = 3, GAP_B = 5, BW_B = 2;

  localparam logic [15:0] BAR16 [16] = '{
    16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0, 16'h07FF, 16'h07FF, 16'h07E0, 16'h07E0,
    16'hF81F, 16'hF81F, 16'hF800, 16'hF800, 16'h001F, 16'h001F, 16'h0000, 16'h0000
  };

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic en_a, en_b;
  logic [1:0] pat_a, pat_b;
  logic [15:0] col_a, col_b;
  logic vs_a, valid_a, done_a, vs_b, valid_b, done_b;
  logic [15:0] data_a, data_b;
  logic [7:0] fcnt_a, fcnt_b;

  int checks = 0;
  int failures = 0;

  // Model state per instance: running flag, cycle within frame, latched config, frame count.
  int cfg_h[2]    = '{H_A, H_B};
  int cfg_v[2]    = '{V_A, V_B};
  int cfg_hb[2]   = '{HB_A, HB_B};
  int cfg_pre[2]  = '{PRE_A, PRE_B};
  int cfg_post[2] = '{POST_A, POST_B};
  int cfg_gap[2]  = '{GAP_A, GAP_B};
  int cfg_bw[2]   = '{BW_A, BW_B};
  bit m_run[2]    = '{1'b0, 1'b0};
  int m_t[2]      = '{0, 0};
  int m_pat[2]    = '{0, 0};
  logic [15:0] m_col[2] = '{16'h0, 16'h0};
  int m_fcnt[2]   = '{0, 0};

  always #5 sys_clk = ~sys_clk;

  frame_src #(.H_ACT(H_A), .V_ACT(V_A), .H_BLANK(HB_A), .V_PRE(PRE_A), .V_POST(POST_A),
              .V_GAP(GAP_A), .BAR_W(BW_A)) u_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .i_en(en_a), .i_pattern(pat_a), .i_color(col_a),
    .o_post_camvs(vs_a), .o_valid(valid_a), .o_data(data_a), .o_frame_done(done_a),
    .o_frame_cnt(fcnt_a)
  );

  frame_src #(.H_ACT(H_B), .V_ACT(V_B), .H_BLANK(HB_B), .V_PRE(PRE_B), .V_POST(POST_B),
              .V_GAP(GAP_B), .BAR_W(BW_B)) u_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .i_en(en_b), .i_pattern(pat_b), .i_color(col_b),
    .o_post_camvs(vs_b), .o_valid(valid_b), .o_data(data_b), .o_frame_done(done_b),
    .o_frame_cnt(fcnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_pix(input int pat, input logic [15:0] col,
                                            input int x, input int y, input int bw);
    int idx;
    case (pat)
      0: begin
        idx = x / bw;
        if (idx > 7) idx = 7;
        case (idx)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      1: return 16'(((x & 31) << 11) | ((y & 63) << 5) | ((x ^ y) & 31));
      2: return col;
      default: return (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Checks one instance against the model, then advances the model to the next edge.
  task automatic compare_inst(input int i, input logic vs, input logic valid,
                              input logic [15:0] data, input logic done, input logic [7:0] fcnt,
                              input logic en, input logic [1:0] pat, input logic [15:0] col);
    string n;
    int per, act_len, u, ln, c;
    logic evs, eval, edone;
    n = (i == 0) ? "a" : "b";
    per     = cfg_pre[i] + cfg_v[i] * (cfg_h[i] + cfg_hb[i]) + cfg_post[i] + cfg_gap[i];
    act_len = per - cfg_gap[i];
    if (sys_rst) begin
      m_run[i]  = 1'b0;
      m_t[i]    = 0;
      m_fcnt[i] = 0;
      check({n, "_rst_vs"}, vs, 0);
      check({n, "_rst_valid"}, valid, 0);
      check({n, "_rst_done"}, done, 0);
      check({n, "_rst_data"}, data, 0);
      check({n, "_rst_cnt"}, fcnt, 0);
    end else begin
      evs   = m_run[i] && (m_t[i] < act_len);
      edone = m_run[i] && (m_t[i] == act_len - 1);
      eval  = 1'b0;
      ln    = 0;
      c     = 0;
      u     = m_t[i] - cfg_pre[i];
      if (m_run[i] && u >= 0 && u < cfg_v[i] * (cfg_h[i] + cfg_hb[i])) begin
        ln   = u / (cfg_h[i] + cfg_hb[i]);
        c    = u % (cfg_h[i] + cfg_hb[i]);
        eval = (c < cfg_h[i]);
      end
      check({n, "_vs"}, vs, evs);
      check({n, "_valid"}, valid, eval);
      check({n, "_done"}, done, edone);
      check({n, "_frame_cnt"}, fcnt, m_fcnt[i]);
      if (eval) check($sformatf("%s_data x=%0d y=%0d", n, c, ln), data,
                      model_pix(m_pat[i], m_col[i], c, ln, cfg_bw[i]));
      if (!m_run[i]) begin
        if (en) begin
          m_run[i] = 1'b1;
          m_t[i]   = 0;
          m_pat[i] = pat;
          m_col[i] = col;
        end
      end else begin
        m_t[i]++;
        if (m_t[i] == per) begin
          m_t[i] = 0;
          if (en) begin
            m_pat[i] = pat;
            m_col[i] = col;
          end else begin
            m_run[i] = 1'b0;
          end
        end
      end
      if (m_run[i] && m_t[i] == act_len - 1) m_fcnt[i] = (m_fcnt[i] + 1) % 256;
    end
  endtask

  initial begin
    forever begin
      @(negedge sys_clk);
      compare_inst(0, vs_a, valid_a, data_a, done_a, fcnt_a, en_a, pat_a, col_a);
      compare_inst(1, vs_b, valid_b, data_b, done_b, fcnt_b, en_b, pat_b, col_b);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int n, hi, lo, nv, k;
    bit got, all_valid;
    logic [15:0] first_px, last_px, p0, p1, p2;
    logic [15:0] line_px [32];

    sys_rst = 1'b1;
    en_a = 1'b0; pat_a = 2'd0; col_a = 16'h0;
    en_b = 1'b0; pat_b = 2'd0; col_b = 16'h0;
    repeat (3) tick();
    check("reset_vs_a", vs_a, 0);
    check("reset_valid_a", valid_a, 0);
    check("reset_cnt_a", fcnt_a, 0);
    check("reset_vs_b", vs_b, 0);
    check("reset_data_b", data_b, 0);
    sys_rst = 1'b0;
    repeat (4) tick();
    check("idle_without_en", vs_a, 0);

    // Instance a: solid 1234, color changed mid-frame, frame geometry 18 high / 5 low.
    pat_a = 2'd2; col_a = 16'h1234; en_a = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!vs_a && n < 50);
    check("a_rise_latency", n, 1);
    hi = 1; nv = 0; got = 1'b0; first_px = '0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!vs_a) break;
      hi++;
      if (hi == 10) col_a = 16'hABCD;
      if (valid_a) begin
        nv++;
        if (!got) begin first_px = data_a; got = 1'b1; end
      end
    end
    check("a_vs_high_cycles", hi, 18);
    check("a_valid_strobes", nv, 8);
    check("a_f1_first_px", first_px, 16'h1234);
    check("a_cnt_after_f1", fcnt_a, 1);
    lo = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (vs_a) break;
      lo++;
    end
    check("a_vs_low_cycles", lo, 5);

    // Frame 2 carries the new color; gradient requested now shows up in frame 3.
    pat_a = 2'd1;
    n = 0;
    while (!valid_a && n < 50) begin tick(); n++; end
    check("a_f2_first_px", data_a, 16'hABCD);
    n = 0;
    while (!done_a && n < 50) begin tick(); n++; end
    n = 0; last_px = '0;
    do begin
      tick(); n++;
      if (valid_a) last_px = data_a;
    end while (!done_a && n < 100);
    check("a_done_period", n, 23);
    check("a_grad_px_3_1", last_px, 16'h1822);
    check("a_cnt_after_f3", fcnt_a, 3);

    // Drop enable in the middle of line 1 of frame 4.
    nv = 0; n = 0;
    while (nv < 6 && n < 100) begin
      tick(); n++;
      if (valid_a) nv++;
    end
    en_a = 1'b0;
    check("a_in_line_at_drop", valid_a, 1);
    n = 0;
    while (!done_a && n < 100) begin tick(); n++; end
    check("a_cnt_after_drop", fcnt_a, 4);
    hi = 0;
    repeat (40) begin
      tick();
      if (vs_a) hi++;
    end
    check("a_vs_after_drop", hi, 0);

    // Instance b: color bars on line 0, then checker on frame 2.
    pat_b = 2'd0; en_b = 1'b1;
    n = 0;
    while (!valid_b && n < 50) begin tick(); n++; end
    all_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      line_px[i] = data_b;
      all_valid  = all_valid & valid_b;
      tick();
    end
    pat_b = 2'd3;
    check("b_line0_contiguous", all_valid, 1);
    for (int i = 0; i < 16; i++) check($sformatf("b_bar_px%0d", i), line_px[i], BAR16[i]);
    for (int i = 14; i < 32; i++) check($sformatf("b_bar_sat_px%0d", i), line_px[i], 16'h0000);
    n = 0;
    while (!done_b && n < 1200) begin tick(); n++; end
    k = 0; n = 0; p0 = 'x; p1 = 'x; p2 = 'x;
    while (k <= 528 && n < 1200) begin
      tick(); n++;
      if (valid_b) begin
        if (k == 16)  p0 = data_b;
        if (k == 512) p1 = data_b;
        if (k == 528) p2 = data_b;
        k++;
      end
    end
    check("b_chk_16_0", p0, 16'hFFFF);
    check("b_chk_16_16", p2, 16'h0000);
    check("b_chk_0_16", p1, 16'hFFFF);

    // Asynchronous reset in the middle of a line.
    check("b_in_line_before_rst", valid_b, 1);
    check("b_cnt_before_rst", fcnt_b, 1);
    #1 sys_rst = 1'b1;
    #1;
    check("b_rst_async_valid", valid_b, 0);
    check("b_rst_async_vs", vs_b, 0);
    check("b_rst_async_cnt", fcnt_b, 0);
    repeat (3) tick();
    sys_rst = 1'b0;
    check("b_vs_at_release", vs_b, 0);
    n = 0;
    do begin tick(); n++; end while (!vs_b && n < 50);
    check("b_rise_after_rst", n, 1);
    repeat (60) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_src.md
FRAME_SRC -- requirements
Module: frame_src

Interface
REQ-001 SHALL provide parameter H_ACT, default 640: active pixels per line.
REQ-002 SHALL provide parameter V_ACT, default 480: active lines per frame.
REQ-003 SHALL provide parameter H_BLANK, default 16: idle cycles after every active line.
REQ-004 SHALL provide parameters V_PRE, default 8, and V_POST, default 8: cycles with vs high and valid low before the first line and after the last line.
REQ-005 SHALL provide parameter V_GAP, default 32: cycles with vs low between frames.
REQ-006 SHALL provide parameter BAR_W, default 80: color-bar width in pixels.
REQ-007 SHALL provide parameter P_W, default 12: width of the pixel and line counters.
REQ-008 sys_clk  in  1  single clock; all logic is rising-edge.
REQ-009 sys_rst  in  1  asynchronous, active-high reset.
REQ-010 i_en  in  1  run enable, sampled only in IDLE and at the end of VGAP.
REQ-011 i_pattern  in  2  pattern select: 0 bars, 1 gradient, 2 solid, 3 checker.
REQ-012 i_color  in  16  RGB565 value for the solid pattern.
REQ-013 o_post_camvs  out  1  frame-valid (vs) level.
REQ-014 o_valid  out  1  pixel strobe.
REQ-015 o_data  out  16  RGB565 pixel, meaningful only while o_valid=1.
REQ-016 o_frame_done  out  1  one-cycle pulse on the last VPOST cycle.
REQ-017 o_frame_cnt  out  8  completed-frame count; wraps 255->0.

Function
REQ-018 The FSM SHALL have the states IDLE, VPRE, LINE, HBLK, VPOST and VGAP.
REQ-019 IDLE SHALL go to VPRE on the cycle after i_en=1 is sampled; otherwise it stays in IDLE.
REQ-020 VPRE SHALL last V_PRE cycles and then go to LINE.
REQ-021 LINE SHALL last H_ACT cycles and then go to HBLK.
REQ-022 HBLK SHALL last H_BLANK cycles, then go to LINE if lines remain, otherwise to VPOST; HBLK is also present after the last line.
REQ-023 VPOST SHALL last V_POST cycles and then go to VGAP.
REQ-024 VGAP SHALL last V_GAP cycles, then go to VPRE if i_en=1, otherwise to IDLE.
REQ-025 o_post_camvs SHALL be 1 in VPRE, LINE, HBLK and VPOST, and 0 in IDLE and VGAP.
REQ-026 o_valid SHALL be 1 only in LINE, exactly H_ACT consecutive cycles per line, and V_ACT lines per frame.
REQ-027 All outputs SHALL be registered, with o_data and o_valid changing on the same edge; latency from FSM entry into LINE to the first o_valid is 0 extra cycles (flag is asserted in the state-entry cycle).
REQ-028 Pixel counter x SHALL run 0..H_ACT-1 within a line, and line counter y SHALL run 0..V_ACT-1; both clear on VPRE entry.
REQ-029 i_pattern and i_color SHALL be latched on VPRE entry and held constant for the whole frame; mid-frame changes have no effect until the next frame.
REQ-030 Pattern 0 (bars): a bar index SHALL advance every BAR_W pixels, saturate at 7 and clear at the start of each line; index 0..7 maps to FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-031 Pattern 1 (gradient): o_data SHALL equal {x[4:0], y[5:0], x[4:0]^y[4:0]}.
REQ-032 Pattern 2 (solid): o_data SHALL equal the latched i_color.
REQ-033 Pattern 3 (checker): o_data SHALL be FFFF when x[4]^y[4]=1, else 0000.
REQ-034 Deasserting i_en mid-frame SHALL NOT truncate the frame; the current frame completes and the FSM goes to IDLE after VGAP.
REQ-035 o_frame_cnt SHALL increment in the o_frame_done cycle.
REQ-036 All widths SHALL be sized so that no counter overflows for H_ACT or V_ACT up to 2^P_W-1.

Reset
REQ-037 While sys_rst=1, the FSM SHALL be in IDLE, all counters 0, and o_post_camvs, o_valid, o_frame_done, o_data and o_frame_cnt all 0.
REQ-038 Reset asserted mid-frame SHALL force the reset values asynchronously, and output SHALL restart from VPRE only after release with i_en=1.

Verification
REQ-039 H_ACT=4, V_ACT=2, H_BLANK=2, V_PRE=V_POST=3, V_GAP=5, i_en held 1 -> vs high for 3+2*(4+2)+3=18 cycles, then low for 5; 8 valid strobes per frame; o_frame_done pulses every 23 cycles.
REQ-040 Pattern 0, H_ACT=16, BAR_W=2 -> line data is FFFF,FFFF,FFE0,FFE0,...,0000,0000; with H_ACT=20, pixels 14..19 are all 0000 (saturation).
REQ-041 Pattern 2, i_color=1234, then i_color=ABCD mid-frame -> all pixels of that frame are 1234; the next frame is ABCD.
REQ-042 Pattern 3, H_ACT=V_ACT=32 -> pixel (16,0)=FFFF, (16,16)=0000, (0,16)=FFFF.
REQ-043 i_en dropped in the middle of line 1 -> the frame completes, o_frame_cnt increments by 1, the FSM reaches IDLE, and vs stays low.
REQ-044 sys_rst pulsed during LINE -> o_valid and o_post_camvs drop in the same cycle (asynchronous), o_frame_cnt=0, and the first vs rises 1 cycle after release with i_en=1.
